alu_pipe_nbit: RTL and testbench

- Parametrised, pipelined successor to the 4-bit signed ALU.
- Signed WIDTH-bit operands, WIDTH+1-bit signed result, 3-bit opcode set with a saturating accumulator.
- Two-stage valid/ready pipeline so it can sit between streaming producers and consumers in the datapath.

---
 rtl/alu_pipe_nbit.sv | 157 +++++++++++++++
 tb/tb_alu_pipe_nbit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_nbit.sv
// Purpose : two-stage pipelined signed WIDTH-bit ALU with an in-order accumulator.
// Latency : 2 cycles from input handshake to out_valid; 1 beat/cycle sustained.
// Backpr. : out_ready=0 freezes stage 2; stage 1 still fills, then in_ready drops (max 2 beats held).
//
// Optional build macro: ALU_ACC_SAT_EN
//   defined     -> ACC saturates to 2^WIDTH-1 / -2^WIDTH on overflow (ovf=1)
//   not defined -> ACC wraps modulo 2^(WIDTH+1) (ovf=1 still flags the wrap)
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake {Opcode, A, B}
//   Opcode [2:0]         0 ADD, 1 SUB, 2 NOT, 3 ROR, 4 AND, 5 XOR, 6 ACC, 7 CLRACC
//   A, B [WIDTH-1:0]     signed operands
//   out_valid / out_ready result handshake
//   C [WIDTH:0]          signed result
//   ovf                  accumulator overflow flag for this result
module alu_pipe_nbit #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH:0]  ACC_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        Opcode,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    C,
    output logic              ovf
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_NOT    = 3'd2,
        OP_ROR    = 3'd3,
        OP_AND    = 3'd4,
        OP_XOR    = 3'd5,
        OP_ACC    = 3'd6,
        OP_CLRACC = 3'd7
    } op_e;

    // Accumulator range limits in WIDTH+1 bits.
    localparam logic [WIDTH:0] ACC_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ACC_MIN = {1'b1, {WIDTH{1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: operand register
    // ------------------------------------------------------------------
    logic              s1_valid;
    op_e               s1_op;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;

    // Stage 2 takes the stage-1 beat whenever its own slot is empty or
    // is being drained this cycle.
    logic              s2_load;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            // Slot is free (or emptying): take a new beat or go idle.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_e'(Opcode);
                s1_a  <= A;
                s1_b  <= B;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compute
    // ------------------------------------------------------------------
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    acc_next;
    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    b_ext;
    logic [WIDTH+1:0]  acc_sum;
    logic              acc_oor;
    logic [WIDTH:0]    res;
    logic              res_ovf;

    always_comb begin
        a_ext    = {s1_a[WIDTH-1], s1_a};
        b_ext    = {s1_b[WIDTH-1], s1_b};
        // One guard bit beyond the accumulator width exposes the true sum;
        // the sum left the accumulator range when the top two bits differ.
        acc_sum  = {acc[WIDTH], acc} + {{2{s1_a[WIDTH-1]}}, s1_a};
        acc_oor  = acc_sum[WIDTH+1] ^ acc_sum[WIDTH];

        res      = '0;
        res_ovf  = 1'b0;
        acc_next = acc;

        case (s1_op)
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: res = a_ext - b_ext;
            OP_NOT: res = ~a_ext;
            OP_ROR: res = {{WIDTH{1'b0}}, |s1_b};
            OP_AND: res = a_ext & b_ext;
            OP_XOR: res = a_ext ^ b_ext;
            OP_ACC: begin
`ifdef ALU_ACC_SAT_EN
                if (acc_oor) begin
                    // Sign of the true sum picks the rail.
                    res = acc_sum[WIDTH+1] ? ACC_MIN : ACC_MAX;
                end else begin
                    res = acc_sum[WIDTH:0];
                end
`else
                res = acc_sum[WIDTH:0];
`endif
                res_ovf  = acc_oor;
                acc_next = res;
            end
            OP_CLRACC: begin
                res      = acc;
                acc_next = ACC_INIT;
            end
            default: begin
                res      = '0;
                res_ovf  = 1'b0;
                acc_next = acc;
            end
        endcase
    end

    // The accumulator only moves on a stage-2 load, so a stalled output
    // never lets later ACC/CLRACC beats overtake earlier ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            C         <= '0;
            ovf       <= 1'b0;
            acc       <= ACC_INIT;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            C         <= res;
            ovf       <= res_ovf;
            acc       <= acc_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
module tb_alu_pipe_nbit;

    localparam int         W        = 4;
    localparam logic [W:0] ACC_INIT = '0;
`ifdef ALU_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   Opcode = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   C;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int c;
        bit o;
    } exp_t;

    exp_t expq[$];
    int   macc;

    alu_pipe_nbit #(.WIDTH(W), .ACC_INIT(ACC_INIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Opcode    (Opcode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic over the opcode rules.
    function automatic void model_beat(input int op, input int a, input int b,
                                       output int c, output bit o);
        int hi, lo, s;
        hi = (1 << W) - 1;
        lo = -(1 << W);
        o  = 1'b0;
        c  = 0;
        case (op)
            0: c = a + b;
            1: c = a - b;
            2: c = -a - 1;
            3: c = (b != 0) ? 1 : 0;
            4: c = a & b;
            5: c = a ^ b;
            6: begin
                s = macc + a;
                if (s > hi || s < lo) begin
                    o = 1'b1;
                    if (SAT) c = (s > hi) ? hi : lo;
                    else     c = (s > hi) ? s - (1 << (W + 1)) : s + (1 << (W + 1));
                end else begin
                    c = s;
                end
                macc = c;
            end
            default: begin
                c    = macc;
                macc = $signed(ACC_INIT);
            end
        endcase
    endfunction

    function automatic logic [W:0] to_c(input int v);
        logic [31:0] t;
        t = v;
        return t[W:0];
    endfunction

    // One clock of stimulus; inputs change at the falling edge and the
    // handshakes are evaluated just after, well before the rising edge.
    task automatic step(input bit iv, input int op, input int a, input int b,
                        input bit ordy, output bit in_hs, output bit out_hs);
        exp_t e;
        logic [31:0] opv, av, bv;
        opv = op; av = a; bv = b;
        @(negedge clk);
        in_valid  = iv;
        Opcode    = opv[2:0];
        A         = av[W-1:0];
        B         = bv[W-1:0];
        out_ready = ordy;
        #1;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (in_hs) begin
            model_beat(op, a, b, e.c, e.o);
            expq.push_back(e);
        end
    endtask

    task automatic drop_front();
        if (expq.size() > 0) void'(expq.pop_front());
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (out_valid !== 1'b0 || C !== '0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: out_valid=%b C=%h ovf=%b want 0/0/0", out_valid, C, ovf);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        macc  = $signed(ACC_INIT);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_ops();
        int op_t[7] = '{0, 1, 2, 3, 3, 4, 5};
        int a_t[7]  = '{7, -8, 5, 0, 0, -1, 5};
        int b_t[7]  = '{7, 7, 0, 0, 4, 6, 3};
        int c_t[7]  = '{14, -15, -6, 0, 1, 6, 6};
        bit ih, oh;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, op_t[i], a_t[i], b_t[i], 1'b1, ih, oh);
            total++;
            if (ih !== 1'b1) begin
                bad++;
                $display("FAIL op%0d_accept: in handshake=%b want 1", i, ih);
            end
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL op%0d_latency: out_valid=%b one cycle after accept, want 0", i, out_valid);
            end
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            total++;
            if (out_valid !== 1'b1 || C !== to_c(c_t[i]) || ovf !== 1'b0) begin
                bad++;
                $display("FAIL op%0d_result: out_valid=%b C=%0d ovf=%b want 1/%0d/0",
                         i, out_valid, $signed(C), ovf, c_t[i]);
            end
            if (oh) drop_front();
        end
    endtask

    task automatic test_acc();
        int op_t[6] = '{7, 6, 6, 6, 7, 6};
        int a_t[6]  = '{0, 7, 7, 7, 0, 1};
        int c_t[6];
        bit o_t[6]  = '{0, 0, 0, 1, 0, 0};
        int ni, no, idx;
        bit ih, oh;
        c_t = '{0, 7, 14, (SAT ? 15 : -11), (SAT ? 15 : -11), 1};
        ni = 0;
        no = 0;
        for (int k = 0; k < 40 && no < 6; k++) begin
            idx = (ni < 6) ? ni : 0;
            step(ni < 6, op_t[idx], a_t[idx], 0, 1'b1, ih, oh);
            if (ih) ni++;
            if (oh) begin
                total++;
                if (C !== to_c(c_t[no]) || ovf !== o_t[no]) begin
                    bad++;
                    $display("FAIL acc_seq%0d: C=%0d ovf=%b want %0d/%b",
                             no, $signed(C), ovf, c_t[no], o_t[no]);
                end
                drop_front();
                no++;
            end
        end
        total++;
        if (no != 6) begin
            bad++;
            $display("FAIL acc_count: results=%0d want 6", no);
        end
    endtask

    task automatic test_back_to_back();
        int ni, no, first;
        bit ih, oh;
        ni = 0;
        no = 0;
        first = -1;
        for (int k = 0; k < 6; k++) begin
            step(ni < 4, 0, ni + 1, ni + 2, 1'b0, ih, oh);
            if (ih) ni++;
        end
        total++;
        if (ni != 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_fill: accepted=%0d in_ready=%b want 2/0", ni, in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || C !== to_c(3)) begin
            bad++;
            $display("FAIL b2b_hold: out_valid=%b C=%0d want 1/3", out_valid, $signed(C));
        end
        for (int k = 0; k < 20 && no < 4; k++) begin
            step(ni < 4, 0, ni + 1, ni + 2, 1'b1, ih, oh);
            if (ih) ni++;
            if (oh) begin
                if (first < 0) first = k;
                total++;
                if (C !== to_c(3 + 2 * no) || k != first + no) begin
                    bad++;
                    $display("FAIL b2b_drain%0d: C=%0d at step %0d want %0d at step %0d",
                             no, $signed(C), k, 3 + 2 * no, first + no);
                end
                drop_front();
                no++;
            end
        end
        total++;
        if (no != 4) begin
            bad++;
            $display("FAIL b2b_count: results=%0d want 4", no);
        end
    endtask

    task automatic test_async_reset();
        bit ih, oh;
        int ni, got;
        step(1'b1, 6, 5, 0, 1'b1, ih, oh);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            if (oh) drop_front();
        end
        ni = 0;
        for (int k = 0; k < 6 && ni < 2; k++) begin
            step(1'b1, 0, 3, 4, 1'b0, ih, oh);
            if (ih) ni++;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || C !== '0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_outputs: out_valid=%b C=%h ovf=%b want 0/0/0", out_valid, C, ovf);
        end
        expq.delete();
        macc = $signed(ACC_INIT);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL async_reset_stale: out_valid=%b at idle step %0d want 0", out_valid, k);
            end
        end
        got = 0;
        step(1'b1, 7, 0, 0, 1'b1, ih, oh);
        for (int k = 0; k < 10 && got == 0; k++) begin
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            if (oh) begin
                got = 1;
                total++;
                if (C !== ACC_INIT) begin
                    bad++;
                    $display("FAIL async_reset_acc: C=%0d want %0d", $signed(C), $signed(ACC_INIT));
                end
                drop_front();
            end
        end
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL async_reset_clracc_timeout: no result");
        end
    endtask

    task automatic test_random();
        bit ih, oh, prev_stall;
        logic [W:0] prev_c;
        logic prev_o;
        exp_t e;
        prev_stall = 1'b0;
        prev_c = '0;
        prev_o = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                 $urandom_range(0, 4) < 3, ih, oh);
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || C !== prev_c || ovf !== prev_o) begin
                    bad++;
                    $display("FAIL rand_stall_%0d: out_valid=%b C=%h ovf=%b want 1/%h/%b",
                             k, out_valid, C, ovf, prev_c, prev_o);
                end
            end
            if (oh) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra_%0d: result C=%h with no beat pending", k, C);
                end else begin
                    e = expq.pop_front();
                    if (C !== to_c(e.c) || ovf !== e.o) begin
                        bad++;
                        $display("FAIL rand_result_%0d: C=%0d ovf=%b want %0d/%b",
                                 k, $signed(C), ovf, e.c, e.o);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c = C;
            prev_o = ovf;
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 0, 0, 0, 1'b1, ih, oh);
            if (oh) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL rand_drain_extra: C=%h with no beat pending", C);
                end else begin
                    e = expq.pop_front();
                    if (C !== to_c(e.c) || ovf !== e.o) begin
                        bad++;
                        $display("FAIL rand_drain_result: C=%0d ovf=%b want %0d/%b",
                                 $signed(C), ovf, e.c, e.o);
                    end
                end
            end
        end
        total++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_lost: pending=%0d out_valid=%b want 0/0", expq.size(), out_valid);
        end
    endtask

    initial begin
        macc = $signed(ACC_INIT);
        test_reset();
        test_ops();
        test_acc();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
